// File: rtl/tick_pkg.sv
// tick_pkg: shared mode/state encodings and small helpers for the multi-channel tick generator.
package tick_pkg;
  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;
  function automatic logic mode_runs(input logic [1:0] m);
    return m == MODE_PERIODIC || m == MODE_ONESHOT;
  endfunction
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one independent down-counting tick/wave/done channel with IDLE/RUN/DONE control.
module tick_channel
  import tick_pkg::*;
#(
  parameter int          CNT_WIDTH      = 32,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 wr_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] period_i,
  input  logic [1:0]           mode_i,
  output logic                 tick_o,
  output logic                 wave_o,
  output logic                 done_o
);
  localparam logic [CNT_WIDTH-1:0] DEF_P = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d, cnt_q, cnt_d;
  logic                   tick_q, tick_d, wave_q, wave_d, done_q, done_d;
  logic                   wr_run, arm, counting, expire;
  assign wr_run   = mode_runs(mode_i) && period_i != '0;
  // a write on the same channel takes precedence over a restart
  assign arm      = !wr_i && start_i && mode_runs(mode_q) && period_q != '0;
  assign counting = enable_i && state_q == ST_RUN;
  assign expire   = counting && cnt_q == '0;
  always_ff @(posedge clk_sys)
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  always_comb
    state_d = wr_i ? (wr_run ? ST_RUN : ST_IDLE) :
              arm  ? ST_RUN :
              (expire && mode_q == MODE_ONESHOT) ? ST_DONE : state_q;
  always_comb begin
    period_d = wr_i ? period_i : period_q;
    mode_d   = wr_i ? mode_e'(mode_i) : mode_q;
    cnt_d    = wr_i            ? period_i - ONE :
               (arm || expire) ? period_q - ONE :
               counting        ? cnt_q - ONE : cnt_q;
    tick_d   = !wr_i && !arm && expire;
    wave_d   = wave_q ^ tick_d;
    done_d   = (wr_i || arm) ? 1'b0 : done_q || (tick_d && mode_q == MODE_ONESHOT);
  end
  always_ff @(posedge clk_sys)
    if (reset) begin
      period_q <= DEF_P;
      mode_q   <= MODE_PERIODIC;
      cnt_q    <= DEF_P - ONE;
      tick_q   <= 1'b0;
      wave_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      wave_q   <= wave_d;
      done_q   <= done_d;
    end
  assign tick_o = tick_q;
  assign wave_o = wave_q;
  assign done_o = done_q;
endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NUM_CH independent programmable tick generators sharing one config write port.
module multi_tick_gen
  import tick_pkg::*;
#(
  parameter int          NUM_CH         = 2,
  parameter int          CNT_WIDTH      = 32,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cfg_we,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_WIDTH-1:0]      cfg_period,
  input  logic [1:0]                cfg_mode,
  input  logic [NUM_CH-1:0]         ch_start,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         wave,
  output logic [NUM_CH-1:0]         done
);
  localparam int CH_W = ch_w(NUM_CH);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .CNT_WIDTH     (CNT_WIDTH),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_ch (
      .clk_sys (clk_sys),
      .reset   (reset),
      .enable_i(enable),
      .wr_i    (cfg_we && cfg_ch == CH_W'(i)),
      .start_i (ch_start[i]),
      .period_i(cfg_period),
      .mode_i  (cfg_mode),
      .tick_o  (tick[i]),
      .wave_o  (wave[i]),
      .done_o  (done[i])
    );
  end
endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: table vectors, corner-case sequences and random traffic against an elapsed-count model.
module tb_multi_tick_gen;
  localparam int NC = 2, CW = 8, DP = 4;
  logic          clk_sys = 1'b0;
  logic          reset, enable, cfg_we;
  logic [0:0]    cfg_ch;
  logic [CW-1:0] cfg_period;
  logic [1:0]    cfg_mode, ch_start, tick, wave, done;
  int            errors = 0, checks = 0;
  int            m_p[NC], m_mode[NC], m_el[NC];
  bit            m_arm[NC];
  logic [NC-1:0] m_tick, m_wave, m_done;
  typedef struct {
    logic r, we;
    int   ch, per, m;
    logic [1:0] t, w;
  } vec_t;
  vec_t tbl[19];
  always #5 clk_sys = ~clk_sys;
  multi_tick_gen #(.NUM_CH(NC), .CNT_WIDTH(CW), .DEFAULT_PERIOD(DP)) dut (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode), .ch_start(ch_start),
    .tick(tick), .wave(wave), .done(done)
  );
  function automatic bit runs(input int m);
    return m == 1 || m == 2;
  endfunction
  function automatic vec_t mk(input logic r, we, input int ch, per, m, input logic [1:0] t, w);
    vec_t v;
    v.r = r; v.we = we; v.ch = ch; v.per = per; v.m = m; v.t = t; v.w = w;
    return v;
  endfunction
  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask
  // elapsed enabled cycles since arming; a tick falls on every multiple of P
  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      if (reset) begin
        m_p[c] = DP; m_mode[c] = 1; m_el[c] = 0; m_arm[c] = 1;
        m_done[c] = 0; m_wave[c] = 0; m_tick[c] = 0;
      end else if (cfg_we && int'(cfg_ch) == c) begin
        m_p[c] = int'(cfg_period); m_mode[c] = int'(cfg_mode); m_el[c] = 0;
        m_done[c] = 0; m_tick[c] = 0; m_arm[c] = runs(m_mode[c]) && m_p[c] != 0;
      end else if (ch_start[c] && runs(m_mode[c]) && m_p[c] != 0) begin
        m_el[c] = 0; m_arm[c] = 1; m_done[c] = 0; m_tick[c] = 0;
      end else if (enable && m_arm[c]) begin
        m_el[c]++;
        m_tick[c] = (m_el[c] % m_p[c]) == 0;
        if (m_tick[c]) begin
          m_wave[c] = ~m_wave[c];
          if (m_mode[c] == 2) begin
            m_done[c] = 1; m_arm[c] = 0;
          end
        end
      end else m_tick[c] = 0;
    end
  endtask
  task automatic step(input logic r, en, we, input int ch, per, m, input logic [1:0] st);
    reset = r; enable = en; cfg_we = we; cfg_ch = 1'(ch);
    cfg_period = CW'(per); cfg_mode = 2'(m); ch_start = st;
    @(posedge clk_sys);
    model_edge();
    #1;
    chk("model_tick", tick, m_tick);
    chk("model_wave", wave, m_wave);
    chk("model_done", done, m_done);
  endtask
  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 2'b00);
  endtask
  initial begin
    tbl[0] = mk(1, 0, 0, 0, 0, 2'b00, 2'b00);
    for (int i = 1; i <= 8; i++)
      tbl[i] = mk(0, 0, 0, 0, 0, (i % 4 == 0) ? 2'b11 : 2'b00, (i >= 4 && i < 8) ? 2'b11 : 2'b00);
    tbl[9]  = mk(0, 1, 0, 3, 1, 2'b00, 2'b00);
    tbl[10] = mk(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[11] = mk(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[12] = mk(0, 0, 0, 0, 0, 2'b11, 2'b11);
    tbl[13] = mk(0, 0, 0, 0, 0, 2'b00, 2'b11);
    tbl[14] = mk(0, 0, 0, 0, 0, 2'b00, 2'b11);
    tbl[15] = mk(0, 0, 0, 0, 0, 2'b01, 2'b10);
    tbl[16] = mk(0, 0, 0, 0, 0, 2'b10, 2'b00);
    tbl[17] = mk(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[18] = mk(0, 0, 0, 0, 0, 2'b01, 2'b01);
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, 1, tbl[i].we, tbl[i].ch, tbl[i].per, tbl[i].m, 2'b00);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].t);
      chk($sformatf("tbl%0d_wave", i), wave, tbl[i].w);
      chk($sformatf("tbl%0d_done", i), done, 2'b00);
    end
    // one-shot on ch1, then rearm with ch_start
    step(1, 1, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 1, 5, 2, 2'b00);
    chk("os_done_clr", {1'b0, done[1]}, 2'b00);
    for (int k = 1; k <= 12; k++) begin
      idle();
      chk($sformatf("os_tick%0d", k), {1'b0, tick[1]}, {1'b0, k == 5});
      chk($sformatf("os_done%0d", k), {1'b0, done[1]}, {1'b0, k >= 5});
    end
    step(0, 1, 0, 0, 0, 0, 2'b10);
    chk("os_restart_done", {1'b0, done[1]}, 2'b00);
    for (int k = 1; k <= 7; k++) begin
      idle();
      chk($sformatf("os2_tick%0d", k), {1'b0, tick[1]}, {1'b0, k == 5});
      chk($sformatf("os2_done%0d", k), {1'b0, done[1]}, {1'b0, k >= 5});
    end
    // P=1 ticks every cycle, then P=0 parks the channel
    step(1, 1, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 0, 1, 1, 2'b00);
    chk("p1_wave0", {1'b0, wave[0]}, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      idle();
      chk($sformatf("p1_tick%0d", k), {1'b0, tick[0]}, 2'b01);
      chk($sformatf("p1_wave%0d", k), {1'b0, wave[0]}, {1'b0, k % 2 == 1});
    end
    step(0, 1, 1, 0, 0, 1, 2'b00);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) idle();
      chk($sformatf("p0_tick%0d", k), {1'b0, tick[0]}, 2'b00);
      chk($sformatf("p0_wave%0d", k), {1'b0, wave[0]}, 2'b00);
    end
    // enable low for 3 cycles delays the tick by 3
    step(1, 1, 0, 0, 0, 0, 2'b00);
    for (int k = 1; k <= 7; k++) begin
      step(0, !(k >= 3 && k <= 5), 0, 0, 0, 0, 2'b00);
      chk($sformatf("en_tick%0d", k), tick, (k == 7) ? 2'b11 : 2'b00);
    end
    // write and start on ch0 together: written P=2 wins; ch1 restarts normally
    step(1, 1, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 0, 2, 1, 2'b11);
    chk("ws_tick0", tick, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk($sformatf("ws_tick%0d", k), tick, (k == 2) ? 2'b01 : (k == 4) ? 2'b11 : 2'b00);
    end
    // reset mid-count overrides a simultaneous write and starts
    idle();
    step(1, 1, 1, 0, 2, 1, 2'b11);
    chk("rst_tick", tick, 2'b00);
    chk("rst_wave", wave, 2'b00);
    chk("rst_done", done, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk($sformatf("rst_after%0d", k), tick, (k == 4) ? 2'b11 : 2'b00);
    end
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] st;
      st[0] = $urandom_range(0, 9) == 0;
      st[1] = $urandom_range(0, 9) == 0;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), st);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
